// File: rtl/imm_decode_pipe_pkg.sv
// Shared types for the decode-stage immediate unit: immediate format
// classification and the RV opcode values that select it.
package imm_decode_pipe_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ZIMM  = 3'd7
    } imm_type_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPI    = 7'b0010011;
    localparam logic [6:0] OPC_OPI32  = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_pipe_extract.sv
// Combinational immediate extraction: one 32-bit instruction in, the
// extended immediate and its format class out.
module imm_extract
    import imm_decode_pipe_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit ENABLE_ZIMM = 1'b1
) (
    input  logic [31:0]     ins,
    output logic [XLEN-1:0] imm,
    output imm_type_t       imm_type
);

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [31:0] shamt_opi, shamt_w, zimm;
    logic [31:0] sel;

    assign opc      = ins[6:0];
    assign funct3   = ins[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    assign i_imm     = {{20{ins[31]}}, ins[31:20]};
    assign s_imm     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign b_imm     = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    assign u_imm     = {ins[31:12], 12'b0};
    assign j_imm     = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    assign shamt_opi = (XLEN == 64) ? {26'b0, ins[25:20]} : {27'b0, ins[24:20]};
    assign shamt_w   = {27'b0, ins[24:20]};
    assign zimm      = {27'b0, ins[19:15]};

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latches.
        sel      = '0;
        imm_type = IMM_NONE;
        case (opc)
            OPC_JALR, OPC_LOAD: begin sel = i_imm; imm_type = IMM_I; end
            OPC_OPI: begin
                sel      = is_shift ? shamt_opi : i_imm;
                imm_type = is_shift ? IMM_SHAMT : IMM_I;
            end
            OPC_OPI32: begin
                sel      = is_shift ? shamt_w : i_imm;
                imm_type = is_shift ? IMM_SHAMT : IMM_I;
            end
            OPC_STORE:          begin sel = s_imm; imm_type = IMM_S; end
            OPC_BRANCH:         begin sel = b_imm; imm_type = IMM_B; end
            OPC_LUI, OPC_AUIPC: begin sel = u_imm; imm_type = IMM_U; end
            OPC_JAL:            begin sel = j_imm; imm_type = IMM_J; end
            OPC_SYSTEM: begin
                if (ENABLE_ZIMM && funct3[2]) begin
                    sel      = zimm;
                    imm_type = IMM_ZIMM;
                end
            end
            default: ;
        endcase
    end

    // Zero-extended fields have bit 31 clear, so one sign extension serves all.
    assign imm = XLEN'($signed(sel));

endmodule

// File: rtl/imm_decode_pipe.sv
// Decode-stage immediate unit: decodes before a two-entry (main + skid)
// registered valid/ready buffer, with flush and a precomputed pc+imm target.
module imm_decode_pipe
    import imm_decode_pipe_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit ENABLE_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ins,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output imm_type_t       out_type,
    output logic [XLEN-1:0] out_target
);

    typedef struct packed {
        logic [31:0]     ins;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_type_t       imm_type;
        logic [XLEN-1:0] target;
    } entry_t;

    logic [XLEN-1:0] new_imm;
    imm_type_t       new_type;
    entry_t          new_entry;
    entry_t          main_d, main_q, skid_d, skid_q;
    logic            main_valid_d, main_valid_q;
    logic            skid_valid_d, skid_valid_q;
    logic            accept, consume;

    imm_extract #(
        .XLEN        (XLEN),
        .ENABLE_ZIMM (ENABLE_ZIMM)
    ) u_extract (
        .ins      (in_ins),
        .imm      (new_imm),
        .imm_type (new_type)
    );

    assign new_entry = '{ins: in_ins, pc: in_pc, imm: new_imm,
                         imm_type: new_type, target: in_pc + new_imm};

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                main_d       = skid_q;
                main_valid_d = skid_valid_q;
                skid_valid_d = 1'b0;
            end
            // in_ready implies an empty skid, so accept never collides with skid->main.
            if (accept) begin
                if (!main_valid_q || consume) begin
                    main_d       = new_entry;
                    main_valid_d = 1'b1;
                end else begin
                    skid_d       = new_entry;
                    skid_valid_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data registers are cleared too, so out_* read as zero/NONE after reset.
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign out_ins    = main_q.ins;
    assign out_pc     = main_q.pc;
    assign out_imm    = main_q.imm;
    assign out_type   = main_q.imm_type;
    assign out_target = main_q.target;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Self-checking bench: three configurations (64/zimm, 64/no-zimm, 32/zimm)
// driven in lockstep and checked against a queue-based reference model.
module tb_imm_decode_pipe;
    import imm_decode_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_ins;
    logic [63:0] in_pc;

    logic in_ready_a, out_valid_a, in_ready_n, out_valid_n, in_ready_w, out_valid_w;
    logic [31:0] out_ins_a, out_ins_n, out_ins_w;
    logic [63:0] out_pc_a, out_imm_a, out_target_a, out_pc_n, out_imm_n, out_target_n;
    logic [31:0] out_pc_w, out_imm_w, out_target_w;
    imm_type_t   out_type_a, out_type_n, out_type_w;

    imm_decode_pipe #(.XLEN(64), .ENABLE_ZIMM(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_ins(in_ins), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_ins(out_ins_a), .out_pc(out_pc_a), .out_imm(out_imm_a), .out_type(out_type_a),
        .out_target(out_target_a));

    imm_decode_pipe #(.XLEN(64), .ENABLE_ZIMM(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_ins(in_ins), .in_pc(in_pc), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_ins(out_ins_n), .out_pc(out_pc_n), .out_imm(out_imm_n), .out_type(out_type_n),
        .out_target(out_target_n));

    imm_decode_pipe #(.XLEN(32), .ENABLE_ZIMM(1'b1)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_ins(in_ins), .in_pc(in_pc[31:0]), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_ins(out_ins_w), .out_pc(out_pc_w), .out_imm(out_imm_w), .out_type(out_type_w),
        .out_target(out_target_w));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        logic [63:0] imm_a, tgt_a, imm_n, tgt_n, imm_w, tgt_w;
        imm_type_t   t_a, t_n, t_w;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        logic [63:0] imm;
        imm_type_t   t;
        logic [63:0] tgt;
        logic [63:0] nz_imm;
        imm_type_t   nz_t;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] popped[$];
    vec_t        tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode from the ISA field definitions, using plain integer arithmetic.
    function automatic void ref_decode(input logic [31:0] ins, input int xlen, input bit zen,
                                       output logic [63:0] imm, output imm_type_t t);
        longint v = 0;
        logic [2:0] f3 = ins[14:12];
        bit shift = (f3 == 3'd1) || (f3 == 3'd5);
        t = IMM_NONE;
        case (ins[6:0])
            OPC_JALR, OPC_LOAD: begin v = longint'($signed(ins[31:20])); t = IMM_I; end
            OPC_OPI: begin
                if (shift) begin v = longint'(ins >> 20) % ((xlen == 64) ? 64 : 32); t = IMM_SHAMT; end
                else begin v = longint'($signed(ins[31:20])); t = IMM_I; end
            end
            OPC_OPI32: begin
                if (shift) begin v = longint'(ins >> 20) % 32; t = IMM_SHAMT; end
                else begin v = longint'($signed(ins[31:20])); t = IMM_I; end
            end
            OPC_STORE:  begin v = longint'($signed({ins[31:25], ins[11:7]})); t = IMM_S; end
            OPC_BRANCH: begin
                v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); t = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin v = longint'($signed(ins & 32'hFFFF_F000)); t = IMM_U; end
            OPC_JAL: begin
                v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); t = IMM_J;
            end
            OPC_SYSTEM: if (zen && ins[14]) begin v = longint'(ins >> 15) % 32; t = IMM_ZIMM; end
            default: ;
        endcase
        imm = v;
        if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
    endfunction

    function automatic exp_t make_exp(input logic [31:0] ins, input logic [63:0] pc);
        exp_t e;
        e.ins = ins;
        e.pc  = pc;
        ref_decode(ins, 64, 1'b1, e.imm_a, e.t_a);
        ref_decode(ins, 64, 1'b0, e.imm_n, e.t_n);
        ref_decode(ins, 32, 1'b1, e.imm_w, e.t_w);
        e.tgt_a = pc + e.imm_a;
        e.tgt_n = pc + e.imm_n;
        e.tgt_w = (pc + e.imm_w) & 64'hFFFF_FFFF;
        return e;
    endfunction

    task automatic compare_front();
        exp_t e = sb[0];
        check("ins_a", {32'b0, out_ins_a}, {32'b0, e.ins});
        check("pc_a", out_pc_a, e.pc);
        check("imm_a", out_imm_a, e.imm_a);
        check("type_a", 64'(out_type_a), 64'(e.t_a));
        check("target_a", out_target_a, e.tgt_a);
        check("imm_nz", out_imm_n, e.imm_n);
        check("type_nz", 64'(out_type_n), 64'(e.t_n));
        check("target_nz", out_target_n, e.tgt_n);
        check("pc_w", {32'b0, out_pc_w}, e.pc & 64'hFFFF_FFFF);
        check("imm_w", {32'b0, out_imm_w}, e.imm_w);
        check("type_w", 64'(out_type_w), 64'(e.t_w));
        check("target_w", {32'b0, out_target_w}, e.tgt_w);
    endtask

    // One clock: drive, check at the falling edge, update the model, return at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic rdy, input logic fl, input logic rst, output logic acc);
        logic cons;
        in_valid = v; in_ins = ins; in_pc = pc; out_ready = rdy; flush = fl; reset = rst;
        @(negedge clk);
        check("out_valid_a", {63'b0, out_valid_a}, {63'b0, sb.size() > 0});
        check("out_valid_nz", {63'b0, out_valid_n}, {63'b0, sb.size() > 0});
        check("out_valid_w", {63'b0, out_valid_w}, {63'b0, sb.size() > 0});
        check("in_ready_a", {63'b0, in_ready_a}, {63'b0, sb.size() < 2});
        check("in_ready_nz", {63'b0, in_ready_n}, {63'b0, sb.size() < 2});
        check("in_ready_w", {63'b0, in_ready_w}, {63'b0, sb.size() < 2});
        if (sb.size() > 0) compare_front();
        acc  = v && (sb.size() < 2) && !fl && !rst;
        cons = rdy && (sb.size() > 0);
        if (rst || fl) begin
            sb.delete();
            acc = 1'b0;
        end else begin
            if (cons) begin
                popped.push_back(sb[0].ins);
                void'(sb.pop_front());
            end
            if (acc) sb.push_back(make_exp(ins, pc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {61'b0, out_valid_a, out_valid_n, out_valid_w}, 64'd0);
        check({tag, "_ready"}, {61'b0, in_ready_a, in_ready_n, in_ready_w}, 64'd7);
        check({tag, "_ins"}, {out_ins_a, out_ins_w}, 64'd0);
        check({tag, "_pc"}, out_pc_a | out_pc_n | {32'b0, out_pc_w}, 64'd0);
        check({tag, "_imm"}, out_imm_a | out_imm_n | {32'b0, out_imm_w}, 64'd0);
        check({tag, "_target"}, out_target_a | out_target_n | {32'b0, out_target_w}, 64'd0);
        check({tag, "_type"}, {55'b0, out_type_a, out_type_n, out_type_w}, 64'd0);
    endtask

    logic        acc;
    logic [31:0] rnd;
    logic [6:0]  opcs[11];

    initial begin
        tbl[0] = '{32'hFFF00093, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 64'h7FFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFF, IMM_I};
        tbl[1] = '{32'hFE000EE3, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFC, IMM_B, 64'h8000_000C,
                   64'hFFFF_FFFF_FFFF_FFFC, IMM_B};
        tbl[2] = '{32'h4010D093, 64'h1000, 64'd1, IMM_SHAMT, 64'h1001, 64'd1, IMM_SHAMT};
        tbl[3] = '{32'h03F09093, 64'h2000, 64'd63, IMM_SHAMT, 64'h203F, 64'd63, IMM_SHAMT};
        tbl[4] = '{32'h300FD073, 64'h3000, 64'd31, IMM_ZIMM, 64'h301F, 64'd0, IMM_NONE};
        tbl[5] = '{32'h800000B7, 64'h10, 64'hFFFF_FFFF_8000_0000, IMM_U, 64'hFFFF_FFFF_8000_0010,
                   64'hFFFF_FFFF_8000_0000, IMM_U};
        tbl[6] = '{32'hFFDFF0EF, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, IMM_J, 64'hFC,
                   64'hFFFF_FFFF_FFFF_FFFC, IMM_J};
        tbl[7] = '{32'hFE113C23, 64'h40, 64'hFFFF_FFFF_FFFF_FFF8, IMM_S, 64'h38,
                   64'hFFFF_FFFF_FFFF_FFF8, IMM_S};
        tbl[8] = '{32'h03F0909B, 64'h0, 64'd31, IMM_SHAMT, 64'd31, 64'd31, IMM_SHAMT};
        tbl[9] = '{32'h002081B3, 64'h55, 64'd0, IMM_NONE, 64'h55, 64'd0, IMM_NONE};
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                 OPC_OPI, OPC_OPI32, OPC_SYSTEM, 7'b0110011};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ins = '0; in_pc = '0;
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1, acc);
        check_reset_outputs("reset");

        // Directed vectors, back-to-back with out_ready high (one per cycle).
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, tbl[i].ins, tbl[i].pc, 1'b1, 1'b0, 1'b0, acc);
            check("tbl_valid", {63'b0, out_valid_a}, 64'd1);
            check("tbl_imm", out_imm_a, tbl[i].imm);
            check("tbl_type", 64'(out_type_a), 64'(tbl[i].t));
            check("tbl_target", out_target_a, tbl[i].tgt);
            check("tbl_nz_imm", out_imm_n, tbl[i].nz_imm);
            check("tbl_nz_type", 64'(out_type_n), 64'(tbl[i].nz_t));
        end
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, acc);

        // Backpressure: A, B fill main and skid; C must wait, then all drain in order.
        popped.delete();
        cycle(1'b1, 32'h00100093, 64'hA0, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00200113, 64'hB0, 1'b0, 1'b0, 1'b0, acc);
        check("c_blocked_ready", {63'b0, in_ready_a}, 64'd0);
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++)
            cycle(1'b1, 32'h00300193, 64'hC0, 1'b1, 1'b0, 1'b0, acc);
        check("c_accepted", {63'b0, acc}, 64'd1);
        repeat (3) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, acc);
        check("order_count", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            check("order_a", {32'b0, popped[0]}, 64'h00100093);
            check("order_b", {32'b0, popped[1]}, 64'h00200113);
            check("order_c", {32'b0, popped[2]}, 64'h00300193);
        end

        // Flush with two entries buffered and a concurrent incoming instruction.
        cycle(1'b1, 32'h00400213, 64'hD0, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00500293, 64'hE0, 1'b0, 1'b0, 1'b0, acc);
        popped.delete();
        cycle(1'b1, 32'h00600313, 64'hF0, 1'b0, 1'b1, 1'b0, acc);
        check("flush_valid", {63'b0, out_valid_a}, 64'd0);
        check("flush_ready", {63'b0, in_ready_a}, 64'd1);
        repeat (3) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, acc);
        check("flush_dropped", 64'(popped.size()), 64'd0);

        // Reset mid-transfer, concurrent with flush and an incoming instruction.
        cycle(1'b1, 32'h00700393, 64'h110, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00800413, 64'h120, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00900493, 64'h130, 1'b1, 1'b1, 1'b1, acc);
        check_reset_outputs("midreset");

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom();
            cycle($urandom_range(0, 3) != 0, {rnd[31:7], opcs[$urandom_range(0, 10)]},
                  {$urandom(), $urandom()}, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
